decode_stage: RTL and testbench

- Pipelined RV32I decode stage. Accepts fetched instruction words over a valid/ready handshake.
- Produces the registered control bundle that drives the ALU and branch/memory logic: alu_op, comp_op, the mux selects, immediates and register indices.
- Single-entry pipeline register with back-pressure and flush. Sits between fetch and execute.

---
 rtl/decode_stage_if.sv | 22 ++
 rtl/decode_stage.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake seen by the decode stage: the incoming
// instruction offer and the outgoing bundle valid/ready with its PC.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;

  // master is the surrounding pipeline (fetch + execute), slave is the stage
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the offered word, captured into
// a single-entry pipeline register with back-pressure, flush and reset.
package decode_pkg;
  typedef enum logic [2:0] {
    ADDER_OP   = 3'd0,
    LUI_OP     = 3'd1,
    COMP_OP    = 3'd2,
    XOR_OP     = 3'd3,
    OR_OP      = 3'd4,
    AND_OP     = 3'd5,
    SHIFTER_OP = 3'd6
  } alu_op_t;

  typedef enum logic [2:0] {
    c_BEQ  = 3'd0,
    c_BNE  = 3'd1,
    c_BLT  = 3'd2,
    c_BGE  = 3'd3,
    c_BLTU = 3'd4,
    c_BGEU = 3'd5,
    c_SLT  = 3'd6,
    c_SLTU = 3'd7
  } comp_t;

  typedef struct packed {
    alu_op_t     alu_op;
    comp_t       comp_op;
    logic        is_imm;
    logic        is_store_op;
    logic        is_auipc;
    logic        subtract;
    logic        shift_right;
    logic        shift_arith;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_load;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic        illegal;
  } ctrl_t;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter bit SUPPRESS_X0_WE = 1'b1,
  parameter bit FENCE_AS_NOP   = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  decode_stage_if.slave bus,
  output alu_op_t      alu_op,
  output comp_t        comp_op,
  output logic         is_imm,
  output logic         is_store_op,
  output logic         is_auipc,
  output logic         subtract,
  output logic         shift_right,
  output logic         shift_arith,
  output logic [31:0]  imm_i,
  output logic [31:0]  imm_s,
  output logic [31:0]  imm_b,
  output logic [31:0]  imm_u,
  output logic [31:0]  imm_j,
  output logic [4:0]   rs1,
  output logic [4:0]   rs2,
  output logic [4:0]   rd,
  output logic         rd_we,
  output logic         is_load,
  output logic         is_branch,
  output logic         is_jal,
  output logic         is_jalr,
  output logic [2:0]   funct3,
  output logic         illegal
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_reg_op;
  logic        f7_base;
  logic        f7_alt;
  logic        accept;
  ctrl_t       ctrl_next;
  ctrl_t       ctrl_reg;
  logic        valid_reg;
  logic [31:0] pc_reg;

  assign instr     = bus.in_instr;
  assign opcode    = instr[6:0];
  assign f3        = instr[14:12];
  assign f7        = instr[31:25];
  assign is_reg_op = (opcode == OPC_OP);
  assign f7_base   = (f7 == 7'b0000000);
  assign f7_alt    = (f7 == 7'b0100000);

  assign bus.in_ready = ~valid_reg | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    ctrl_next         = '0;
    ctrl_next.alu_op  = ADDER_OP;
    ctrl_next.comp_op = c_BEQ;
    ctrl_next.imm_i   = {{20{instr[31]}}, instr[31:20]};
    ctrl_next.imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    ctrl_next.imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    ctrl_next.imm_u   = {instr[31:12], 12'b0};
    ctrl_next.imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    ctrl_next.rs1     = instr[19:15];
    ctrl_next.rs2     = instr[24:20];
    ctrl_next.rd      = instr[11:7];
    ctrl_next.funct3  = f3;

    case (opcode)
      OPC_LUI: begin
        ctrl_next.alu_op = LUI_OP;
        ctrl_next.rd_we  = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_next.is_auipc = 1'b1;
        ctrl_next.rd_we    = 1'b1;
      end
      OPC_OP_IMM, OPC_OP: begin
        // Register and immediate forms share one funct3 map; only funct7 rules differ.
        ctrl_next.is_imm = ~is_reg_op;
        ctrl_next.rd_we  = 1'b1;
        case (f3)
          3'b000: begin
            ctrl_next.subtract = is_reg_op & f7_alt;
            ctrl_next.illegal  = is_reg_op & ~(f7_base | f7_alt);
          end
          3'b001: begin
            ctrl_next.alu_op  = SHIFTER_OP;
            ctrl_next.illegal = ~f7_base;
          end
          3'b010: begin
            ctrl_next.alu_op   = COMP_OP;
            ctrl_next.comp_op  = c_SLT;
            ctrl_next.subtract = 1'b1;
            ctrl_next.illegal  = is_reg_op & ~f7_base;
          end
          3'b011: begin
            ctrl_next.alu_op   = COMP_OP;
            ctrl_next.comp_op  = c_SLTU;
            ctrl_next.subtract = 1'b1;
            ctrl_next.illegal  = is_reg_op & ~f7_base;
          end
          3'b100: begin
            ctrl_next.alu_op  = XOR_OP;
            ctrl_next.illegal = is_reg_op & ~f7_base;
          end
          3'b101: begin
            ctrl_next.alu_op      = SHIFTER_OP;
            ctrl_next.shift_right = 1'b1;
            ctrl_next.shift_arith = instr[30];
            ctrl_next.illegal     = ~(f7_base | f7_alt);
          end
          3'b110: begin
            ctrl_next.alu_op  = OR_OP;
            ctrl_next.illegal = is_reg_op & ~f7_base;
          end
          default: begin
            ctrl_next.alu_op  = AND_OP;
            ctrl_next.illegal = is_reg_op & ~f7_base;
          end
        endcase
      end
      OPC_BRANCH: begin
        ctrl_next.alu_op    = COMP_OP;
        ctrl_next.subtract  = 1'b1;
        ctrl_next.is_branch = 1'b1;
        case (f3)
          3'b000:  ctrl_next.comp_op = c_BEQ;
          3'b001:  ctrl_next.comp_op = c_BNE;
          3'b100:  ctrl_next.comp_op = c_BLT;
          3'b101:  ctrl_next.comp_op = c_BGE;
          3'b110:  ctrl_next.comp_op = c_BLTU;
          3'b111:  ctrl_next.comp_op = c_BGEU;
          default: ctrl_next.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl_next.is_imm  = 1'b1;
        ctrl_next.is_load = 1'b1;
        ctrl_next.rd_we   = 1'b1;
        ctrl_next.illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
      end
      OPC_STORE: begin
        ctrl_next.is_store_op = 1'b1;
        ctrl_next.illegal     = f3[2] | (f3 == 3'b011);
      end
      OPC_JAL: begin
        ctrl_next.is_jal = 1'b1;
        ctrl_next.rd_we  = 1'b1;
      end
      OPC_JALR: begin
        ctrl_next.is_imm  = 1'b1;
        ctrl_next.is_jalr = 1'b1;
        ctrl_next.rd_we   = 1'b1;
        ctrl_next.illegal = (f3 != 3'b000);
      end
      OPC_MISC_MEM: begin
        ctrl_next.illegal = ~FENCE_AS_NOP;
      end
      default: begin
        ctrl_next.illegal = 1'b1;
      end
    endcase

    // Illegal words still flow downstream so execute can trap, but must not
    // write registers or start memory/control-flow activity.
    if (ctrl_next.illegal) begin
      ctrl_next.rd_we       = 1'b0;
      ctrl_next.is_load     = 1'b0;
      ctrl_next.is_branch   = 1'b0;
      ctrl_next.is_jal      = 1'b0;
      ctrl_next.is_jalr     = 1'b0;
      ctrl_next.is_store_op = 1'b0;
    end
    if (SUPPRESS_X0_WE && (ctrl_next.rd == 5'd0)) begin
      ctrl_next.rd_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      pc_reg    <= '0;
    end else begin
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (accept) begin
        valid_reg <= 1'b1;
      end else if (bus.out_ready) begin
        valid_reg <= 1'b0;
      end
      // A flushed word is dropped entirely rather than captured invalid.
      if (accept && !flush) begin
        ctrl_reg <= ctrl_next;
        pc_reg   <= bus.in_pc;
      end
    end
  end

  assign bus.out_valid = valid_reg;
  assign bus.out_pc    = pc_reg;
  assign alu_op        = ctrl_reg.alu_op;
  assign comp_op       = ctrl_reg.comp_op;
  assign is_imm        = ctrl_reg.is_imm;
  assign is_store_op   = ctrl_reg.is_store_op;
  assign is_auipc      = ctrl_reg.is_auipc;
  assign subtract      = ctrl_reg.subtract;
  assign shift_right   = ctrl_reg.shift_right;
  assign shift_arith   = ctrl_reg.shift_arith;
  assign imm_i         = ctrl_reg.imm_i;
  assign imm_s         = ctrl_reg.imm_s;
  assign imm_b         = ctrl_reg.imm_b;
  assign imm_u         = ctrl_reg.imm_u;
  assign imm_j         = ctrl_reg.imm_j;
  assign rs1           = ctrl_reg.rs1;
  assign rs2           = ctrl_reg.rs2;
  assign rd            = ctrl_reg.rd;
  assign rd_we         = ctrl_reg.rd_we;
  assign is_load       = ctrl_reg.is_load;
  assign is_branch     = ctrl_reg.is_branch;
  assign is_jal        = ctrl_reg.is_jal;
  assign is_jalr       = ctrl_reg.is_jalr;
  assign funct3        = ctrl_reg.funct3;
  assign illegal       = ctrl_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed test-plan sequence followed by randomized traffic, checked against
// an instruction-level reference decoder and a cycle-level handshake model.
module tb_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        flush;
  decode_stage_if bus();
  alu_op_t     alu_op;
  comp_t       comp_op;
  logic        is_imm, is_store_op, is_auipc, subtract, shift_right, shift_arith;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [4:0]  rs1, rs2, rd;
  logic        rd_we, is_load, is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic        illegal;

  decode_stage #(.SUPPRESS_X0_WE(1'b1), .FENCE_AS_NOP(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .alu_op(alu_op), .comp_op(comp_op), .is_imm(is_imm), .is_store_op(is_store_op),
    .is_auipc(is_auipc), .subtract(subtract), .shift_right(shift_right),
    .shift_arith(shift_arith), .imm_i(imm_i), .imm_s(imm_s), .imm_b(imm_b),
    .imm_u(imm_u), .imm_j(imm_j), .rs1(rs1), .rs2(rs2), .rd(rd), .rd_we(rd_we),
    .is_load(is_load), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .illegal(illegal)
  );

  typedef struct packed {
    alu_op_t     alu;
    comp_t       comp;
    logic        is_imm, is_store_op, is_auipc, subtract, shift_right, shift_arith;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we, is_load, is_branch, is_jal, is_jalr;
    logic [2:0]  funct3;
    logic        illegal;
    logic [31:0] pc;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t m;
  bit   m_valid;
  bit   m_fresh;

  logic [6:0] opcs [10] = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h63, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h0F};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference: what each RV32I word should mean.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t       e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         ok;
    bit         reg_op;
    alu_op_t    atab [8] = '{ADDER_OP, SHIFTER_OP, COMP_OP, COMP_OP, XOR_OP, SHIFTER_OP, OR_OP, AND_OP};
    comp_t      ctab [8] = '{c_BEQ, c_BNE, c_BEQ, c_BEQ, c_BLT, c_BGE, c_BLTU, c_BGEU};
    e = '0;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    e.pc     = pc;
    e.alu    = ADDER_OP;
    e.comp   = c_BEQ;
    e.imm_i  = 32'(w[31:20]) - (w[31] ? 32'd4096 : 32'd0);
    e.imm_s  = 32'({w[31:25], w[11:7]}) - (w[31] ? 32'd4096 : 32'd0);
    e.imm_b  = 32'({w[31], w[7], w[30:25], w[11:8], 1'b0}) - (w[31] ? 32'd8192 : 32'd0);
    e.imm_u  = 32'(w[31:12]) * 32'd4096;
    e.imm_j  = 32'({w[31], w[19:12], w[20], w[30:21], 1'b0}) - (w[31] ? 32'h0020_0000 : 32'd0);
    e.rs1    = w[19:15];
    e.rs2    = w[24:20];
    e.rd     = w[11:7];
    e.funct3 = f3;
    ok = 1'b1;
    reg_op = (opc == 7'h33);
    case (opc)
      7'h37: begin e.alu = LUI_OP; e.rd_we = 1; end
      7'h17: begin e.is_auipc = 1; e.rd_we = 1; end
      7'h13, 7'h33: begin
        e.alu = atab[f3];
        e.is_imm = !reg_op;
        e.rd_we = 1;
        if (f3 == 3'd2) e.comp = c_SLT;
        if (f3 == 3'd3) e.comp = c_SLTU;
        e.subtract    = (f3 == 3'd2) || (f3 == 3'd3) || (reg_op && f3 == 3'd0 && f7 == 7'h20);
        e.shift_right = (f3 == 3'd5);
        e.shift_arith = (f3 == 3'd5) && w[30];
        if (f3 == 3'd1)      ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else if (reg_op)     ok = (f7 == 7'h00) || (f3 == 3'd0 && f7 == 7'h20);
      end
      7'h63: begin
        e.alu = COMP_OP; e.subtract = 1; e.is_branch = 1;
        e.comp = ctab[f3];
        ok = (f3 != 3'd2) && (f3 != 3'd3);
      end
      7'h03: begin
        e.is_imm = 1; e.is_load = 1; e.rd_we = 1;
        ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      end
      7'h23: begin e.is_store_op = 1; ok = (f3 <= 3'd2); end
      7'h6F: begin e.is_jal = 1; e.rd_we = 1; end
      7'h67: begin e.is_imm = 1; e.is_jalr = 1; e.rd_we = 1; ok = (f3 == 3'd0); end
      7'h0F: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    e.illegal = !ok;
    if (!ok) begin
      e.rd_we = 0; e.is_load = 0; e.is_branch = 0; e.is_jal = 0; e.is_jalr = 0; e.is_store_op = 0;
    end
    if (e.rd == 5'd0) e.rd_we = 0;
    return e;
  endfunction

  task automatic compare_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid || m_fresh) begin
      check("out_pc", bus.out_pc, m.pc);
      check("imm_i", imm_i, m.imm_i);
      check("imm_s", imm_s, m.imm_s);
      check("imm_b", imm_b, m.imm_b);
      check("imm_u", imm_u, m.imm_u);
      check("imm_j", imm_j, m.imm_j);
      check("rs1", 32'(rs1), 32'(m.rs1));
      check("rs2", 32'(rs2), 32'(m.rs2));
      check("rd", 32'(rd), 32'(m.rd));
      check("funct3", 32'(funct3), 32'(m.funct3));
      check("illegal", 32'(illegal), 32'(m.illegal));
      check("rd_we", 32'(rd_we), 32'(m.rd_we));
      check("class_flags", {27'd0, is_load, is_branch, is_jal, is_jalr, is_store_op},
            {27'd0, m.is_load, m.is_branch, m.is_jal, m.is_jalr, m.is_store_op});
      if (!m.illegal) begin
        check("alu_op", 32'(alu_op), 32'(m.alu));
        check("comp_op", 32'(comp_op), 32'(m.comp));
        check("alu_ctl", {26'd0, is_imm, is_auipc, subtract, shift_right, shift_arith, 1'b0},
              {26'd0, m.is_imm, m.is_auipc, m.subtract, m.shift_right, m.shift_arith, 1'b0});
      end
    end
  endtask

  // One clock: check registered outputs, drive inputs, check in_ready, advance model.
  task automatic cycle(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl, input bit rst);
    bit acc;
    @(negedge clk);
    compare_outputs();
    bus.in_valid  = iv;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
    reset         = rst;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(!m_valid || ordy));
    @(posedge clk);
    acc = iv && (!m_valid || ordy);
    m_fresh = 0;
    if (rst) begin
      m_valid = 0; m = '0; m.alu = ADDER_OP; m.comp = c_BEQ; m_fresh = 1;
    end else if (fl) begin
      m_valid = 0;
    end else if (acc) begin
      m_valid = 1; m = ref_decode(ins, pc);
    end else if (ordy) begin
      m_valid = 0;
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) begin
      w[6:0] = opcs[$urandom_range(0, 9)];
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    m = '0; m.alu = ADDER_OP; m.comp = c_BEQ; m_valid = 0; m_fresh = 1;

    cycle(0, 32'h0, 32'h0, 1, 0, 1);
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'(ADDER_OP));

    cycle(1, 32'h00500093, 32'h100, 1, 0, 0);
    #2;
    check("addi_valid", 32'(bus.out_valid), 32'd1);
    check("addi_imm_i", imm_i, 32'd5);
    check("addi_rd_we", {30'd0, rd_we, is_imm}, 32'd3);

    cycle(1, 32'h402081B3, 32'h104, 1, 0, 0);
    #2;
    check("sub_subtract", {31'd0, subtract}, 32'd1);
    check("sub_regs", {17'd0, rs1, rs2, rd}, {17'd0, 5'd1, 5'd2, 5'd3});

    cycle(1, 32'h0020C463, 32'h108, 1, 0, 0);
    #2;
    check("blt_comp", 32'(comp_op), 32'(c_BLT));
    check("blt_imm_b", imm_b, 32'd8);

    // BLT is now held while execute stalls; SRAI waits.
    cycle(1, 32'h40335293, 32'h10C, 0, 0, 0);
    cycle(1, 32'h40335293, 32'h10C, 0, 0, 0);
    #2;
    check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    check("hold_branch", {31'd0, is_branch}, 32'd1);
    cycle(1, 32'h40335293, 32'h10C, 1, 0, 0);
    #2;
    check("srai_shift", {27'd0, shift_right, shift_arith, 3'd0}, {27'd0, 1'b1, 1'b1, 3'd0});
    check("srai_shamt", 32'(imm_i[4:0]), 32'd3);

    cycle(1, 32'h00500093, 32'h110, 1, 0, 0);
    cycle(1, 32'h402081B3, 32'h114, 1, 1, 0);
    #2;
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    cycle(1, 32'h123453B7, 32'h118, 1, 0, 0);
    #2;
    check("lui_imm_u", imm_u, 32'h12345000);
    check("lui_alu", 32'(alu_op), 32'(LUI_OP));

    cycle(1, 32'h00000000, 32'h11C, 1, 0, 0);
    #2;
    check("zero_illegal", {30'd0, illegal, rd_we}, 32'd2);
    cycle(1, 32'h00000013, 32'h120, 1, 0, 0);
    #2;
    check("nop_legal", {30'd0, illegal, rd_we}, 32'd0);
    cycle(1, 32'h00500093, 32'h124, 0, 0, 0);
    cycle(0, 32'h0, 32'h0, 0, 0, 1);
    #2;
    check("rst_hold_valid", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, gen_instr(), $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 96) == 0);
    end
    @(negedge clk);
    compare_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
